os_inst_dispatch: RTL and testbench
===================================

# os_inst_dispatch

Instruction dispatcher for the output-stationary core. It receives the 40-bit instruction word produced by the host or sequencer, registers it, and derives the aligned control signals. These cover activation/weight SRAM access, L0 and IFIFO write and read strobes with SRAM-latency alignment, and PE mode/execute/load. After an output-stationary shift sequence, it autonomously drains the OFIFO into psum memory (pmem), reading `col` words and writing them to consecutive pmem addresses.

## Interface
Parameters:
- `col`, 8, number of OFIFO words drained per shift sequence
- `pmem_aw`, 9, pmem address width

Ports:
- `clk` input 1: single clock; all state updates on rising edge
- `reset` input 1: asynchronous, active-high
- `inst` input 40: [39] psum_bypass, [38] acc, [37] CEN_pmem, [36] WEN_pmem, [35:27] A_pmem, [26] CEN1_xmem, [25:18] A1_xmem, [17] CEN0_xmem, [16] WEN0_xmem, [15:8] A0_xmem, [7] ofifo_rd, [6] ififo_wr, [5] ififo_rd, [4] l0_rd, [3] l0_wr, [2] mode, [1] execute, [0] load
- `l0_ready` input 1: L0 can accept a write
- `ififo_ready` input 1: IFIFO can accept a write
- `ofifo_valid` input 1: OFIFO holds at least one full row
- `CEN0_xmem`, `WEN0_xmem` output 1 each; `A0_xmem` output 8
- `CEN1_xmem` output 1; `A1_xmem` output 8
- `CEN_pmem`, `WEN_pmem` output 1 each; `A_pmem` output 9
- `l0_wr`, `l0_rd`, `ififo_wr`, `ififo_rd`, `ofifo_rd` output 1 each
- `mode`, `execute`, `load`, `acc`, `psum_bypass` output 1 each
- `drain_busy` output 1: drain FSM not in IDLE
- `drain_done` output 1: one-cycle pulse when drain completes
- `err` output 1: sticky protocol error; cleared only by reset

## Operation
- `inst` is registered into `inst_r` every cycle.
- SRAM controls (CEN/WEN/A for xmem0 and xmem1), `mode`, `execute`, `load`, `acc`, and `psum_bypass` are driven directly from `inst_r`.
- xmem0 read (CEN0=0, WEN0=1 in `inst_r`) sets pending bit `p0`. The next cycle, `l0_wr` asserts, ORed with explicit `inst_r[3]`.
- xmem1 read (CEN1=0) sets pending bit `p1`. The next cycle, `ififo_wr` asserts, ORed with `inst_r[6]`.
- `l0_rd` is `l0_wr` delayed one cycle, ORed with `inst_r[4]`. `ififo_rd` is `ififo_wr` delayed one cycle, ORed with `inst_r[5]`.
- Overflow: if `l0_wr` would assert while `l0_ready`=0, the write is suppressed and `err` is set. The same rule applies to `ififo_wr` and `ififo_ready`. The matching delayed read is also suppressed.
- Drain FSM states:
  - IDLE: on `inst_r` with mode=1 and load=1, latch `base`=A_pmem field, clear `cnt`, go to SHIFT.
  - SHIFT: stay while `inst_r` load=1. When load=0, go to WAIT.
  - WAIT: when `ofifo_valid`=1, go to READ.
  - READ: assert `ofifo_rd` each cycle that `ofifo_valid`=1 and `cnt`<`col`; increment `cnt` per read. When `cnt` reaches `col` and the last pmem write has issued, go to DONE.
  - DONE: pulse `drain_done`, return to IDLE.
- pmem write for each OFIFO read is issued one cycle later (OFIFO read latency 1): CEN_pmem=0, WEN_pmem=0, A_pmem=`base`+k for the k-th word. The address wraps modulo 2^`pmem_aw`.
- When the FSM is IDLE, `ofifo_rd` and the pmem controls follow `inst_r`.
- When the FSM is not IDLE, pmem and `ofifo_rd` are owned by the FSM. Any `inst_r` with CEN_pmem=0 or ofifo_rd=1 in that state is ignored and sets `err`.
- mode=1, load=1 while the FSM is in WAIT, READ, or DONE: ignored for drain purposes and sets `err`.

## Timing
- Reset values:
  - All CEN and WEN outputs 1.
  - All address outputs 0.
  - All strobes, `mode`/`execute`/`load`/`acc`/`psum_bypass`, `drain_busy`, `drain_done`, and `err` 0.
  - FSM in IDLE; `inst_r`, pending bits, and counters cleared.
- Latency from `inst` to SRAM and PE controls: 1 cycle.
- xmem read to `l0_wr`/`ififo_wr`: +1 cycle after the SRAM control is driven.
- Write strobe to read strobe: +1 cycle.
- `ofifo_rd` to pmem write: 1 cycle.
- Minimum drain duration from leaving SHIFT: 1 (WAIT) + `col` (READ) + 1 (trailing write) + 1 (DONE).
- `ofifo_valid` dropping mid-READ: stall with no read and no `cnt` change, then resume.
- Reset asserted mid-drain: returns to IDLE immediately. Outstanding pmem writes are abandoned and pending strobes are cleared.
- Back-to-back xmem reads produce back-to-back `l0_wr` pulses, subject to `l0_ready`.

## Test plan
- Nine consecutive xmem0 reads at A0=0..8 with `l0_ready`=1 -> `l0_wr` high for 9 cycles starting 2 cycles after the first `inst`; `l0_rd` is the same pattern 1 cycle later; `err`=0.
- Same as above, with `l0_ready`=0 on the 5th write -> that `l0_wr` and its `l0_rd` are suppressed; `err`=1 from then until reset.
- 16 cycles of mode=1, load=1 with A_pmem=0x1F0, then load=0; `ofifo_valid`=1 held -> 8 `ofifo_rd` pulses; pmem writes to 0x1F0..0x1F7; single `drain_done` pulse; `drain_busy` falls with it.
- Drain with base 0x1FC -> write addresses 0x1FC..0x1FF, then 0x000..0x003 (wrap).
- `ofifo_valid` toggled low for 3 cycles after the 4th read -> exactly 8 reads total, no duplicate addresses; `inst` pmem request issued during drain sets `err`.
- Reset pulsed during READ after 3 reads -> all outputs at reset values within the same cycle; the next shift sequence drains 8 fresh words from its new base.

Source files
------------

// File: rtl/os_inst_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : os_inst_dispatch                                                  |
// | Brief   : Instruction dispatcher and OFIFO-to-pmem drain for the OS core.   |
// | Revision: 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module os_inst_dispatch #(
  parameter int col     = 8,
  parameter int pmem_aw = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [39:0]        inst,
  input  logic               l0_ready,
  input  logic               ififo_ready,
  input  logic               ofifo_valid,
  output logic               CEN0_xmem,
  output logic               WEN0_xmem,
  output logic [7:0]         A0_xmem,
  output logic               CEN1_xmem,
  output logic [7:0]         A1_xmem,
  output logic               CEN_pmem,
  output logic               WEN_pmem,
  output logic [pmem_aw-1:0] A_pmem,
  output logic               l0_wr,
  output logic               l0_rd,
  output logic               ififo_wr,
  output logic               ififo_rd,
  output logic               ofifo_rd,
  output logic               mode,
  output logic               execute,
  output logic               load,
  output logic               acc,
  output logic               psum_bypass,
  output logic               drain_busy,
  output logic               drain_done,
  output logic               err
);

  localparam int c_cnt_w = $clog2(col + 1);
  // Idle instruction: every SRAM chip-enable and write-enable deasserted.
  localparam logic [39:0] c_inst_nop = 40'h30_0403_0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_WAIT  = 3'd2,
    S_READ  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [39:0]          r_inst;
  logic                 r_p0;
  logic                 r_p1;
  logic                 r_l0_wr_d;
  logic                 r_ififo_wr_d;
  logic                 r_err;
  logic [pmem_aw-1:0]   r_base;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_wr_pend;
  logic [pmem_aw-1:0]   r_wr_addr;

  logic w_l0_req, w_l0_wr, w_l0_ovf;
  logic w_if_req, w_if_wr, w_if_ovf;
  logic w_rd_fsm, w_mode_load, w_host_pmem, w_proto_err, w_drain_done;

  assign w_l0_req    = r_p0 | r_inst[3];
  assign w_l0_wr     = w_l0_req & l0_ready;
  assign w_l0_ovf    = w_l0_req & ~l0_ready;
  assign w_if_req    = r_p1 | r_inst[6];
  assign w_if_wr     = w_if_req & ififo_ready;
  assign w_if_ovf    = w_if_req & ~ififo_ready;

  assign w_mode_load = r_inst[2] & r_inst[0];
  assign w_host_pmem = ~r_inst[37] | r_inst[7];
  assign w_rd_fsm    = (r_state == S_READ) && ofifo_valid && (r_cnt < c_cnt_w'(col));
  assign w_proto_err = ((r_state != S_IDLE) && w_host_pmem) ||
                       (w_mode_load && (r_state == S_WAIT || r_state == S_READ ||
                                        r_state == S_DONE));

  always_comb begin
    w_state_nxt  = r_state;
    w_drain_done = 1'b0;
    unique case (r_state)
      S_IDLE:  if (w_mode_load) w_state_nxt = S_SHIFT;
      S_SHIFT: if (!r_inst[0]) w_state_nxt = S_WAIT;
      S_WAIT:  if (ofifo_valid) w_state_nxt = S_READ;
      // cnt==col means the trailing pmem write is on the bus this cycle.
      S_READ:  if (r_cnt == c_cnt_w'(col)) w_state_nxt = S_DONE;
      S_DONE: begin
        w_drain_done = 1'b1;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inst       <= c_inst_nop;
      r_p0         <= 1'b0;
      r_p1         <= 1'b0;
      r_l0_wr_d    <= 1'b0;
      r_ififo_wr_d <= 1'b0;
      r_err        <= 1'b0;
      r_state      <= S_IDLE;
      r_base       <= '0;
      r_cnt        <= '0;
      r_wr_pend    <= 1'b0;
      r_wr_addr    <= '0;
    end else begin
      r_inst       <= inst;
      r_p0         <= ~r_inst[17] & r_inst[16];
      r_p1         <= ~r_inst[26];
      r_l0_wr_d    <= w_l0_wr;
      r_ififo_wr_d <= w_if_wr;
      r_err        <= r_err | w_l0_ovf | w_if_ovf | w_proto_err;
      r_state      <= w_state_nxt;
      if (r_state == S_IDLE && w_mode_load) begin
        r_base <= pmem_aw'(r_inst[35:27]);
        r_cnt  <= '0;
      end else if (w_rd_fsm) begin
        r_cnt  <= r_cnt + 1'b1;
      end
      r_wr_pend <= w_rd_fsm;
      if (w_rd_fsm) r_wr_addr <= r_base + pmem_aw'(r_cnt);
    end
  end

  assign CEN0_xmem   = r_inst[17];
  assign WEN0_xmem   = r_inst[16];
  assign A0_xmem     = r_inst[15:8];
  assign CEN1_xmem   = r_inst[26];
  assign A1_xmem     = r_inst[25:18];
  assign mode        = r_inst[2];
  assign execute     = r_inst[1];
  assign load        = r_inst[0];
  assign acc         = r_inst[38];
  assign psum_bypass = r_inst[39];

  assign l0_wr       = w_l0_wr;
  assign l0_rd       = r_l0_wr_d | r_inst[4];
  assign ififo_wr    = w_if_wr;
  assign ififo_rd    = r_ififo_wr_d | r_inst[5];

  // Outside IDLE the drain owns pmem and the OFIFO read port.
  always_comb begin
    if (r_state == S_IDLE) begin
      CEN_pmem = r_inst[37];
      WEN_pmem = r_inst[36];
      A_pmem   = pmem_aw'(r_inst[35:27]);
      ofifo_rd = r_inst[7];
    end else begin
      CEN_pmem = ~r_wr_pend;
      WEN_pmem = ~r_wr_pend;
      A_pmem   = r_wr_addr;
      ofifo_rd = w_rd_fsm;
    end
  end

  assign drain_busy = (r_state != S_IDLE);
  assign drain_done = w_drain_done;
  assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_os_inst_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_os_inst_dispatch                                               |
// | Brief   : Randomised and directed checks of os_inst_dispatch vs a model.    |
// | Revision: 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_os_inst_dispatch;

  localparam int          COL     = 8;
  localparam logic [39:0] NOP     = 40'h30_0403_0000;
  localparam logic [42:0] RST_VEC = {1'b1, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 9'h000, 13'h0};
  localparam int P_IDLE = 0, P_SHIFT = 1, P_WAIT = 2, P_READ = 3, P_DONE = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [39:0] inst;
  logic        l0_ready, ififo_ready, ofifo_valid;
  logic        CEN0_xmem, WEN0_xmem, CEN1_xmem, CEN_pmem, WEN_pmem;
  logic [7:0]  A0_xmem, A1_xmem;
  logic [8:0]  A_pmem;
  logic        l0_wr, l0_rd, ififo_wr, ififo_rd, ofifo_rd;
  logic        mode, execute, load, acc, psum_bypass, drain_busy, drain_done, err;

  os_inst_dispatch #(.col(COL), .pmem_aw(9)) dut (
    .clk(clk), .reset(reset), .inst(inst), .l0_ready(l0_ready),
    .ififo_ready(ififo_ready), .ofifo_valid(ofifo_valid),
    .CEN0_xmem(CEN0_xmem), .WEN0_xmem(WEN0_xmem), .A0_xmem(A0_xmem),
    .CEN1_xmem(CEN1_xmem), .A1_xmem(A1_xmem),
    .CEN_pmem(CEN_pmem), .WEN_pmem(WEN_pmem), .A_pmem(A_pmem),
    .l0_wr(l0_wr), .l0_rd(l0_rd), .ififo_wr(ififo_wr), .ififo_rd(ififo_rd),
    .ofifo_rd(ofifo_rd), .mode(mode), .execute(execute), .load(load),
    .acc(acc), .psum_bypass(psum_bypass), .drain_busy(drain_busy),
    .drain_done(drain_done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int l0_wr_cnt, l0_rd_cnt, rd_cnt, done_cnt, first_l0_wr;
  logic [8:0] wr_log[$];

  // Reference model: stimulus-history view of the dispatcher.
  logic [39:0] m_inst;
  bit          m_p0, m_p1, m_l0d, m_ifd, m_err;
  int          m_phase, m_nread;
  logic [8:0]  m_base;
  logic [8:0]  m_wq[$];

  task automatic model_reset();
    m_inst = NOP; m_p0 = 0; m_p1 = 0; m_l0d = 0; m_ifd = 0; m_err = 0;
    m_phase = P_IDLE; m_nread = 0; m_base = '0; m_wq.delete();
  endtask

  function automatic bit model_ofifo_read();
    return (m_phase == P_READ) && ofifo_valid && (m_nread < COL);
  endfunction

  function automatic logic [42:0] model_out(output logic [42:0] mask);
    logic l0w, l0r, ifw, ifr, ofr, cp, wp;
    logic [8:0] ap;
    mask = '1;
    l0w  = (m_p0 | m_inst[3]) & l0_ready;
    ifw  = (m_p1 | m_inst[6]) & ififo_ready;
    l0r  = m_l0d | m_inst[4];
    ifr  = m_ifd | m_inst[5];
    if (m_phase == P_IDLE) begin
      cp = m_inst[37]; wp = m_inst[36]; ap = m_inst[35:27]; ofr = m_inst[7];
    end else begin
      ofr = model_ofifo_read();
      if (m_wq.size() > 0) begin
        cp = 1'b0; wp = 1'b0; ap = m_wq[0];
      end else begin
        cp = 1'b1; wp = 1'b1; ap = '0; mask[21:13] = '0;
      end
    end
    return {m_inst[17], m_inst[16], m_inst[15:8], m_inst[26], m_inst[25:18],
            cp, wp, ap, l0w, l0r, ifw, ifr, ofr,
            m_inst[2], m_inst[1], m_inst[0], m_inst[38], m_inst[39],
            m_phase != P_IDLE, m_phase == P_DONE, m_err};
  endfunction

  task automatic model_step();
    bit l0q, ifq, ml, rd, bad;
    if (reset) begin model_reset(); return; end
    l0q = m_p0 | m_inst[3];
    ifq = m_p1 | m_inst[6];
    ml  = m_inst[2] & m_inst[0];
    rd  = model_ofifo_read();
    bad = (l0q && !l0_ready) || (ifq && !ififo_ready) ||
          (m_phase != P_IDLE && (!m_inst[37] || m_inst[7])) ||
          (ml && m_phase >= P_WAIT);
    m_err = m_err | bad;
    m_l0d = l0q & l0_ready;
    m_ifd = ifq & ififo_ready;
    m_p0  = !m_inst[17] && m_inst[16];
    m_p1  = !m_inst[26];
    m_wq.delete();
    if (rd) m_wq.push_back(m_base + 9'(m_nread));
    case (m_phase)
      P_IDLE:  if (ml) begin m_phase = P_SHIFT; m_base = m_inst[35:27]; m_nread = 0; end
      P_SHIFT: if (!m_inst[0]) m_phase = P_WAIT;
      P_WAIT:  if (ofifo_valid) m_phase = P_READ;
      P_READ:  if (m_nread == COL) m_phase = P_DONE; else if (rd) m_nread++;
      default: m_phase = P_IDLE;
    endcase
    m_inst = inst;
  endtask

  function automatic logic [42:0] dut_vec();
    return {CEN0_xmem, WEN0_xmem, A0_xmem, CEN1_xmem, A1_xmem, CEN_pmem, WEN_pmem,
            A_pmem, l0_wr, l0_rd, ififo_wr, ififo_rd, ofifo_rd, mode, execute,
            load, acc, psum_bypass, drain_busy, drain_done, err};
  endfunction

  task automatic check(input string name, input logic [42:0] act, input logic [42:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    l0_wr_cnt = 0; l0_rd_cnt = 0; rd_cnt = 0; done_cnt = 0; first_l0_wr = -1;
    wr_log.delete();
  endtask

  task automatic cycle(input logic [39:0] i_inst, input logic i_l0r, input logic i_ifr,
                       input logic i_ov, input logic i_rst);
    logic [42:0] e, m, a;
    @(negedge clk);
    inst = i_inst; l0_ready = i_l0r; ififo_ready = i_ifr; ofifo_valid = i_ov; reset = i_rst;
    #1;
    if (reset) model_reset();
    e = model_out(m);
    a = dut_vec();
    check("outputs", a & m, e & m);
    if (l0_wr) begin l0_wr_cnt++; if (first_l0_wr < 0) first_l0_wr = cyc; end
    if (l0_rd) l0_rd_cnt++;
    if (drain_busy && ofifo_rd) rd_cnt++;
    if (drain_busy && !CEN_pmem && !WEN_pmem) wr_log.push_back(A_pmem);
    if (drain_done) done_cnt++;
    model_step();
    cyc++;
  endtask

  function automatic logic [39:0] xr0(input int a);
    logic [39:0] v;
    v = NOP; v[17] = 1'b0; v[15:8] = 8'(a);
    return v;
  endfunction

  function automatic logic [39:0] shift_inst(input logic [8:0] base);
    logic [39:0] v;
    v = NOP; v[35:27] = base; v[2] = 1'b1; v[0] = 1'b1;
    return v;
  endfunction

  function automatic logic [39:0] rnd_inst();
    logic [63:0] r;
    logic [39:0] v;
    r = {$urandom(), $urandom()};
    v = r[39:0];
    v[37] = ($urandom_range(0, 7) != 0);
    v[26] = ($urandom_range(0, 3) != 0);
    v[17] = ($urandom_range(0, 3) != 0);
    v[7]  = ($urandom_range(0, 15) == 0);
    v[6]  = ($urandom_range(0, 7) == 0);
    v[5]  = ($urandom_range(0, 7) == 0);
    v[4]  = ($urandom_range(0, 7) == 0);
    v[3]  = ($urandom_range(0, 7) == 0);
    return v;
  endfunction

  task automatic do_shift(input logic [8:0] base);
    for (int i = 0; i < 16; i++) cycle(shift_inst(base), 1, 1, 1, 0);
  endtask

  task automatic check_addrs(input string name, input logic [8:0] base);
    check({name, "_nwr"}, 43'(wr_log.size()), 43'(COL));
    for (int i = 0; i < COL && i < wr_log.size(); i++)
      check({name, "_addr"}, 43'(wr_log[i]), 43'(base + 9'(i)));
  endtask

  initial begin
    logic [8:0] wrap_exp[8];
    int lows;
    bit did_rst;
    wrap_exp = '{9'h1FC, 9'h1FD, 9'h1FE, 9'h1FF, 9'h000, 9'h001, 9'h002, 9'h003};
    reset = 1'b1; inst = NOP; l0_ready = 1; ififo_ready = 1; ofifo_valid = 0;
    model_reset();
    clear_logs();
    cycle(NOP, 1, 1, 0, 1);
    cycle(NOP, 1, 1, 0, 1);
    check("reset_state", dut_vec(), RST_VEC);

    // Nine back-to-back xmem0 reads.
    clear_logs();
    begin
      int c0;
      c0 = cyc;
      for (int i = 0; i < 9; i++) cycle(xr0(i), 1, 1, 0, 0);
      for (int i = 0; i < 4; i++) cycle(NOP, 1, 1, 0, 0);
      check("l0_wr_first", 43'(first_l0_wr), 43'(c0 + 2));
    end
    check("l0_wr_count", 43'(l0_wr_cnt), 43'd9);
    check("l0_rd_count", 43'(l0_rd_cnt), 43'd9);
    check("err_clean", 43'(err), 43'd0);

    // Same, with L0 full on the fifth write.
    cycle(NOP, 1, 1, 0, 1);
    clear_logs();
    for (int i = 0; i < 9; i++) begin
      cycle(xr0(i), (i != 6), 1, 0, 0);
      if (i == 5) check("err_before_ovf", 43'(err), 43'd0);
    end
    for (int i = 0; i < 6; i++) cycle(NOP, 1, 1, 0, 0);
    check("ovf_l0_wr_count", 43'(l0_wr_cnt), 43'd8);
    check("ovf_l0_rd_count", 43'(l0_rd_cnt), 43'd8);
    check("ovf_err_sticky", 43'(err), 43'd1);

    // Plain drain from 0x1F0.
    cycle(NOP, 1, 1, 0, 1);
    clear_logs();
    do_shift(9'h1F0);
    for (int j = 0; j < 20; j++) cycle(NOP, 1, 1, 1, 0);
    check("drain_reads", 43'(rd_cnt), 43'd8);
    check_addrs("drain", 9'h1F0);
    check("drain_done_cnt", 43'(done_cnt), 43'd1);
    check("drain_busy_end", 43'(drain_busy), 43'd0);
    check("drain_err", 43'(err), 43'd0);

    // Address wrap.
    clear_logs();
    do_shift(9'h1FC);
    for (int j = 0; j < 20; j++) cycle(NOP, 1, 1, 1, 0);
    check("wrap_nwr", 43'(wr_log.size()), 43'd8);
    for (int i = 0; i < 8 && i < wr_log.size(); i++)
      check("wrap_addr", 43'(wr_log[i]), 43'(wrap_exp[i]));

    // OFIFO stall plus a host pmem request during the drain.
    clear_logs();
    lows = 0;
    do_shift(9'h020);
    for (int j = 0; j < 30; j++) begin
      logic v;
      logic [39:0] ii;
      v = 1'b1;
      if (rd_cnt >= 4 && lows < 3) begin v = 1'b0; lows++; end
      ii = NOP;
      if (j == 2) begin
        check("err_before_req", 43'(err), 43'd0);
        ii[37] = 1'b0;
      end
      cycle(ii, 1, 1, v, 0);
    end
    check("stall_reads", 43'(rd_cnt), 43'd8);
    check_addrs("stall", 9'h020);
    check("stall_req_err", 43'(err), 43'd1);

    // Reset mid-READ, then a fresh drain.
    cycle(NOP, 1, 1, 0, 1);
    clear_logs();
    did_rst = 0;
    do_shift(9'h100);
    for (int j = 0; j < 20 && !did_rst; j++) begin
      if (rd_cnt == 3) begin
        cycle(NOP, 1, 1, 1, 1);
        check("midread_reset", dut_vec(), RST_VEC);
        did_rst = 1;
      end else begin
        cycle(NOP, 1, 1, 1, 0);
      end
    end
    check("midread_reset_hit", 43'(did_rst), 43'd1);
    clear_logs();
    do_shift(9'h0A5);
    for (int j = 0; j < 20; j++) cycle(NOP, 1, 1, 1, 0);
    check_addrs("fresh", 9'h0A5);
    check("fresh_done_cnt", 43'(done_cnt), 43'd1);

    // Randomised traffic against the model.
    for (int k = 0; k < 3000; k++)
      cycle(rnd_inst(), ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 4) != 0), ($urandom_range(0, 149) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
